sa_kl_req_gen: RTL

Parametrised backward-extension request generator for the SMEM pipeline. It accepts one occurrence-state token per handshake and derives the backward interval bounds k and l from p_x0, p_x2 and the primary index. It then issues one or two occurrence-table line reads for those bounds and emits the updated token to the read-queue stage. It replaces the fixed 64/42-bit stall-driven stage with valid/ready handshakes on all three sides, configurable widths, and optional same-line request merging.

---
 rtl/sa_kl_req_gen.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/sa_kl_req_gen.sv
// rtl/sa_kl_req_gen.sv - backward-extension k/l request generator with valid/ready handshakes
// Optional same-line request merging is enabled by defining KL_REQ_MERGE_EN.
module sa_kl_req_gen #(
    parameter int CNT_W      = 64,
    parameter int ADDR_W     = 42,
    parameter int LINE_SHIFT = 7,
    parameter int IDX_MSB    = 34,
    parameter int ADDR_PAD   = 4,
    parameter int PTR_W      = 7,
    parameter int PAYLOAD_W  = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [5:0]           in_status,
    input  logic                 in_finish,
    input  logic [CNT_W-1:0]     in_p_x0,
    input  logic [CNT_W-1:0]     in_p_x2,
    input  logic [CNT_W-1:0]     in_primary,
    input  logic [PTR_W-1:0]     in_mem_wr_addr,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 req_valid,
    input  logic                 req_ready,
    output logic [ADDR_W-1:0]    req_addr,
    output logic                 req_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [5:0]           out_status,
    output logic                 out_finish,
    output logic [CNT_W-1:0]     out_k,
    output logic [CNT_W-1:0]     out_l,
    output logic [PTR_W-1:0]     out_mem_size,
    output logic [PAYLOAD_W-1:0] out_payload
);

    localparam logic [5:0] BCK_INI = 6'h04;
    localparam logic [5:0] BCK_RUN = 6'h05;
    localparam logic [5:0] BCK_END = 6'h06;
    localparam logic [5:0] BUBBLE  = 6'h30;
    localparam int         IDX_W   = IDX_MSB - LINE_SHIFT + 1;

    typedef enum logic [1:0] {IDLE, REQ_K, REQ_L, EMIT} state_t;

    state_t                 state;
    logic [CNT_W-1:0]       k_r;
    logic [CNT_W-1:0]       l_r;
    logic [PTR_W-1:0]       mem_r;
    logic [PAYLOAD_W-1:0]   pay_r;
    logic                   ini_r;

    logic [5:0]             eff_status;
    logic [CNT_W-1:0]       kt;
    logic [CNT_W-1:0]       lt;
    logic [CNT_W-1:0]       k_nxt;
    logic [CNT_W-1:0]       l_nxt;
    logic                   capture;
    logic                   merge;

    // Line address: index bits [IDX_MSB:LINE_SHIFT] shifted up by ADDR_PAD, zero-extended.
    function automatic logic [ADDR_W-1:0] line_addr(input logic [CNT_W-1:0] x);
        logic [CNT_W-1:0] idx;
        idx = (x >> LINE_SHIFT) & ((CNT_W'(1) << IDX_W) - CNT_W'(1));
        return ADDR_W'(idx) << ADDR_PAD;
    endfunction

    assign eff_status = in_finish ? BCK_END : in_status;
    assign kt         = in_p_x0 - CNT_W'(1);
    assign lt         = kt + in_p_x2;
    assign k_nxt      = (kt >= in_primary) ? kt - CNT_W'(1) : kt;
    assign l_nxt      = (lt >= in_primary) ? lt - CNT_W'(1) : lt;

    assign in_ready   = (state == IDLE) | ((state == EMIT) & out_ready);
    assign capture    = in_valid & in_ready;

`ifdef KL_REQ_MERGE_EN
    assign merge = (line_addr(k_r) == line_addr(l_r));
`else
    assign merge = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            k_r          <= '0;
            l_r          <= '0;
            mem_r        <= '0;
            pay_r        <= '0;
            ini_r        <= 1'b0;
            req_valid    <= 1'b0;
            req_addr     <= '0;
            req_tag      <= 1'b0;
            out_valid    <= 1'b0;
            out_status   <= BUBBLE;
            out_finish   <= 1'b0;
            out_k        <= '0;
            out_l        <= '0;
            out_mem_size <= '0;
            out_payload  <= '0;
        end else begin
            case (state)
                IDLE, EMIT: begin
                    if (state == EMIT && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                    if (capture) begin
                        if (eff_status == BCK_INI || eff_status == BCK_RUN) begin
                            k_r       <= k_nxt;
                            l_r       <= l_nxt;
                            mem_r     <= in_mem_wr_addr;
                            pay_r     <= in_payload;
                            ini_r     <= (eff_status == BCK_INI);
                            req_valid <= 1'b1;
                            req_tag   <= 1'b0;
                            req_addr  <= line_addr(k_nxt);
                            state     <= REQ_K;
                        end else if (eff_status == BCK_END) begin
                            // Finish token: emitted directly as a bubble with zeroed bounds.
                            out_valid    <= 1'b1;
                            out_status   <= BUBBLE;
                            out_finish   <= 1'b1;
                            out_k        <= '0;
                            out_l        <= '0;
                            out_mem_size <= in_mem_wr_addr;
                            out_payload  <= '0;
                            state        <= EMIT;
                        end
                    end
                end
                REQ_K, REQ_L: begin
                    if (req_ready) begin
                        if (state == REQ_K && !merge) begin
                            req_tag  <= 1'b1;
                            req_addr <= line_addr(l_r);
                            state    <= REQ_L;
                        end else begin
                            req_valid    <= 1'b0;
                            out_valid    <= 1'b1;
                            out_status   <= BCK_RUN;
                            out_finish   <= 1'b0;
                            out_k        <= k_r;
                            out_l        <= l_r;
                            out_mem_size <= ini_r ? '0 : mem_r;
                            out_payload  <= pay_r;
                            state        <= EMIT;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
